// File: rtl/ofm_writeback.sv
// Output feature-map writeback: rescales, saturates and stores PE results in raster order,
// accumulating across input-channel tiles by read-modify-write. Optional ReLU: OFM_WRITEBACK_RELU_EN.
module ofm_writeback #(
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned OUT_SIZE    = 28,
  parameter int unsigned OUT_CHANNEL = 6,
  parameter int unsigned IN_TILES    = 1,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ACC_W-1:0]  res_data,
  output logic              out_ena,
  output logic              out_wea,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_din,
  input  logic [DATA_W-1:0] out_dout,
  output logic              sat_flag
);

  localparam int unsigned CntW = 16;
  localparam logic signed [ACC_W:0] SatMax = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SatMin = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StFirst, StRd, StWr, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         t_q, t_d, m_q, m_d, r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic signed [ACC_W-1:0] s_q, s_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W-1:0] s_in;
  logic signed [ACC_W:0]   v;
  logic [DATA_W-1:0]       wr_data;
  logic                    clamp;
  logic                    wr_en, rd_en;
  logic                    c_wrap, r_wrap, m_wrap, last_tile, tile_end, layer_last;

  assign s_in = $signed(res_data) >>> FRAC_BITS;

  // Writes/reads are suppressed during the reset cycle so an abandoned layer never touches memory.
  assign wr_en = reset_n & (((state_q == StFirst) & res_valid) | (state_q == StWr));
  assign rd_en = reset_n & (state_q == StRd) & res_valid;

  assign c_wrap     = (c_q == CntW'(OUT_SIZE - 1));
  assign r_wrap     = (r_q == CntW'(OUT_SIZE - 1));
  assign m_wrap     = (m_q == CntW'(OUT_CHANNEL - 1));
  assign last_tile  = (t_q == CntW'(IN_TILES - 1));
  assign tile_end   = c_wrap & r_wrap & m_wrap;
  assign layer_last = tile_end & last_tile;

  // Result datapath: scale, optionally accumulate with stored partial sum, saturate.
  always_comb begin
    if (state_q == StWr) begin
      v = {{(ACC_W+1-DATA_W){out_dout[DATA_W-1]}}, out_dout} + {s_q[ACC_W-1], s_q};
    end else begin
      v = {s_in[ACC_W-1], s_in};
    end
    clamp   = 1'b0;
    wr_data = v[DATA_W-1:0];
    if (v > SatMax) begin
      wr_data = SatMax[DATA_W-1:0];
      clamp   = 1'b1;
    end else if (v < SatMin) begin
      wr_data = SatMin[DATA_W-1:0];
      clamp   = 1'b1;
    end
`ifdef OFM_WRITEBACK_RELU_EN
    if (last_tile && wr_data[DATA_W-1]) begin
      wr_data = '0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      t_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      s_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      m_q     <= m_d;
      r_q     <= r_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      s_q     <= s_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    m_d     = m_q;
    r_d     = r_q;
    c_d     = c_q;
    addr_d  = addr_q;
    s_d     = s_q;
    sat_d   = sat_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFirst;
          t_d     = '0;
          m_d     = '0;
          r_d     = '0;
          c_d     = '0;
          addr_d  = '0;
          sat_d   = 1'b0;
        end
      end
      StRd: begin
        if (res_valid) begin
          s_d     = s_in;
          state_d = StWr;
        end
      end
      StDone:  state_d = StIdle;
      default: ;
    endcase

    // Address tracks m*OUT_SIZE^2 + r*OUT_SIZE + c incrementally since results arrive in raster order.
    if (wr_en) begin
      sat_d  = sat_q | clamp;
      addr_d = addr_q + 1'b1;
      c_d    = c_wrap ? '0 : c_q + 1'b1;
      if (c_wrap) r_d = r_wrap ? '0 : r_q + 1'b1;
      if (c_wrap && r_wrap) m_d = m_wrap ? '0 : m_q + 1'b1;
      if (tile_end) begin
        t_d    = t_q + 1'b1;
        addr_d = '0;
      end
      if (layer_last) begin
        state_d = StDone;
      end else if (tile_end || state_q == StWr) begin
        state_d = StRd;
      end else begin
        state_d = StFirst;
      end
    end
  end

  always_comb begin
    busy      = (state_q == StFirst) || (state_q == StRd) || (state_q == StWr);
    done      = (state_q == StDone);
    res_ready = reset_n & ((state_q == StFirst) || (state_q == StRd));
    out_ena   = wr_en | rd_en;
    out_wea   = wr_en;
    out_addr  = (wr_en | rd_en) ? addr_q : '0;
    out_din   = wr_en ? wr_data : '0;
    sat_flag  = sat_q;
  end

endmodule

// File: doc/ofm_writeback.md
Name: ofm_writeback

Overview:
- Write-side counterpart of the conv address controller. That controller reads the ifm and weight buffers; this block writes PE-array results into the output feature-map buffer.
- Accepts accumulated results in raster order: input-channel tile, then output channel m, then row r, then column c.
- Rescales and saturates each result, then writes it to the output buffer.
- For tiles after the first, it does a read-modify-write so partial sums accumulate across input-channel groups.

Parameters:
- ACC_W, 32, width of the incoming accumulator result (signed).
- DATA_W, 16, width of an output buffer word (signed fixed point).
- FRAC_BITS, 8, arithmetic right shift applied to each result before it is stored.
- OUT_SIZE, 28, output feature map height and width.
- OUT_CHANNEL, 6, number of output channels.
- IN_TILES, 1, number of input-channel groups (n/4) summed into each output (1..16).
- ADDR_W, 16, width of the output buffer address.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins a layer; ignored while busy
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last write
- res_valid  in  1  result available
- res_ready  out  1  block accepts res_data this cycle
- res_data  in  ACC_W  signed accumulator result
- out_ena  out  1  output buffer port enable
- out_wea  out  1  output buffer write enable
- out_addr  out  ADDR_W  output buffer address
- out_din  out  DATA_W  write data
- out_dout  in  DATA_W  read data, valid one cycle after a read is issued
- sat_flag  out  1  sticky: some stored value was clamped; cleared on start

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; counters t, m, r, c = 0.
  - busy, done, res_ready, out_ena, out_wea, sat_flag = 0; out_addr = 0; out_din = 0.
  - Reset mid-layer abandons the layer immediately; no write occurs in or after the reset cycle.
- Address: out_addr = m*OUT_SIZE*OUT_SIZE + r*OUT_SIZE + c, truncated to ADDR_W. Computed from registered counters, never with a multiplier on the result path.
- Scaling: s = res_data >>> FRAC_BITS (arithmetic shift).
- Tile 0: v = s.
- Tile > 0: v = sign-extended out_dout + s, computed in ACC_W+1 bits.
- Saturation: v is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp sets sat_flag.
- State machine:
  - IDLE: res_ready=0. On start: busy=1, sat_flag=0, counters cleared, go to FIRST if t==0 else RD (t is always 0 here).
  - FIRST (t==0): res_ready=1.
    - On res_valid&res_ready, in the same cycle: out_ena=1, out_wea=1, out_addr=current, out_din=sat(v).
    - Throughput is one result per cycle.
  - RD (t>0): res_ready=1.
    - On handshake: latch s, drive out_ena=1, out_wea=0, out_addr=current, then go to WR.
  - WR: res_ready=0.
    - out_dout is valid this cycle. Drive out_ena=1, out_wea=1, same out_addr, out_din=sat(v).
    - Then return to RD. Throughput is one result per 2 cycles.
  - Counter advance happens after each write:
    - c wraps at OUT_SIZE-1, which increments r.
    - r wraps at OUT_SIZE-1, which increments m.
    - m wraps at OUT_CHANNEL-1, which increments t and resets m, r, c to 0.
  - Layer end: a write with t=IN_TILES-1, m=OUT_CHANNEL-1, r=c=OUT_SIZE-1 goes to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
  - Going from tile 0 to tile 1 enters RD in the next cycle with no bubble.
- Buffer signals: out_ena and out_wea are 0 in every cycle without a read or write.
- Write ordering: a WR-state write and the next RD-state read are never in the same cycle.
- Handshake: res_valid with res_ready=0 is held by the source and not consumed. res_valid in IDLE or DONE is ignored.

Optional Feature:
- Macro: OFM_WRITEBACK_RELU_EN.
- Defined: on the last tile (t==IN_TILES-1), negative saturated values are written as 0. sat_flag behaviour is unchanged. Earlier tiles store signed partial sums unchanged.
- Undefined: no ReLU; values are stored signed.

Test Plan:
- Single-tile layer, defaults, res_data=i<<8 for result index i, res_valid held high:
  - 4704 writes in 4704 consecutive cycles.
  - Address 843 (m=1, r=2, c=3) holds 843.
  - Last address is 4703.
  - done pulses once, one cycle after the final write.
- IN_TILES=2, both tiles res_data=0x0000_0300:
  - Tile 1 alternates read cycle / write cycle with res_ready low in WR.
  - Final buffer value 6 everywhere.
  - Total layer cycles 4704+9408.
- Saturation: res_data=0x0100_0000 -> stored 0x7FFF, sat_flag=1. res_data=0xFF00_0000 -> stored 0x8000. A following start clears sat_flag.
- Backpressure: res_valid toggled at random ~50% -> no result lost or duplicated; addresses strictly sequential; stored data matches the golden model.
- Reset mid-layer: reset_n low for 1 cycle after 100 writes.
  - All outputs read 0 the next cycle; no further writes.
  - A new start restarts at address 0.
- With OFM_WRITEBACK_RELU_EN: IN_TILES=2, tile0 = -5<<8 and tile1 = 2<<8 -> stored 0.
  - With IN_TILES=1, res_data = -5<<8 -> stored 0.
  - Without the macro, the same inputs store -3 and -5.
